// File: rtl/bus_load_regs.sv
// bus_load_regs: destination side of the shared datapath bus.
// Captures BusMuxOut into every register whose load strobe is high
// (R0-R15, HI, LO, Y, IR, MAR, MDR, PC) and presents each value as a flat output.
// MDR can load from memory, and PC can increment-on-load.
// A registered strobe count and a sticky multi-load error flag are kept for diagnostics.
// Optional build macro R0_BA_GATE_EN adds input BAout.
// While BAout is high, R0_q reads as zero; the stored R0 value is untouched.

// Single loadable register with asynchronous clear to a fixed value.
module loadReg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Capture d on a strobed edge, otherwise hold
    always_ff @(posedge clock or posedge clear) begin
        if (clear)     q <= RESET_VAL;
        else if (load) q <= d;
    end
endmodule

module bus_load_regs #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  PC_RESET  = '0,
    parameter int                MAX_LOADS = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] BusMuxOut,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    input  logic [15:0]      Rin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             Yin,
    input  logic             IRin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             PCin,
    input  logic             IncPC,
`ifdef R0_BA_GATE_EN
    input  logic             BAout,
`endif
    output logic [WIDTH-1:0] R0_q,
    output logic [WIDTH-1:0] R1_q,
    output logic [WIDTH-1:0] R2_q,
    output logic [WIDTH-1:0] R3_q,
    output logic [WIDTH-1:0] R4_q,
    output logic [WIDTH-1:0] R5_q,
    output logic [WIDTH-1:0] R6_q,
    output logic [WIDTH-1:0] R7_q,
    output logic [WIDTH-1:0] R8_q,
    output logic [WIDTH-1:0] R9_q,
    output logic [WIDTH-1:0] R10_q,
    output logic [WIDTH-1:0] R11_q,
    output logic [WIDTH-1:0] R12_q,
    output logic [WIDTH-1:0] R13_q,
    output logic [WIDTH-1:0] R14_q,
    output logic [WIDTH-1:0] R15_q,
    output logic [WIDTH-1:0] HI_q,
    output logic [WIDTH-1:0] LO_q,
    output logic [WIDTH-1:0] Y_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] MDR_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [4:0]       load_count,
    output logic             load_err
);
    localparam int NUM_GPR  = 16;
    localparam int NUM_SPC  = 5;
    localparam int NUM_STRB = NUM_GPR + NUM_SPC + 2;

    logic [NUM_GPR-1:0][WIDTH-1:0] gprQ;
    logic [NUM_SPC-1:0][WIDTH-1:0] spcQ;
    logic [NUM_SPC-1:0]            spcLoad;
    logic [NUM_STRB-1:0]           strobes;
    logic [WIDTH-1:0]              mdrD;
    logic [WIDTH-1:0]              pcD;
    logic [4:0]                    loadSum;

    // Plain bus-loaded registers: HI, LO, Y, IR, MAR (index order)
    assign spcLoad = {MARin, IRin, Yin, LOin, HIin};
    assign strobes = {PCin, MDRin, spcLoad, Rin};

    genvar g;
    generate
        for (g = 0; g < NUM_GPR; g++) begin : genGpr
            loadReg #(.WIDTH(WIDTH)) uReg (
                .clock(clock), .clear(clear), .load(Rin[g]), .d(BusMuxOut), .q(gprQ[g])
            );
        end
        for (g = 0; g < NUM_SPC; g++) begin : genSpc
            loadReg #(.WIDTH(WIDTH)) uReg (
                .clock(clock), .clear(clear), .load(spcLoad[g]), .d(BusMuxOut), .q(spcQ[g])
            );
        end
    endgenerate

    // MDR source: memory when Read, otherwise the bus
    assign mdrD = Read ? Mdatain : BusMuxOut;
    loadReg #(.WIDTH(WIDTH)) uMdr (
        .clock(clock), .clear(clear), .load(MDRin), .d(mdrD), .q(MDR_q)
    );

    // PC increment wraps naturally at 2^WIDTH
    assign pcD = IncPC ? (PC_q + {{(WIDTH-1){1'b0}}, 1'b1}) : BusMuxOut;
    loadReg #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) uPc (
        .clock(clock), .clear(clear), .load(PCin), .d(pcD), .q(PC_q)
    );

    // Popcount of this cycle's load strobes (IncPC and Read are qualifiers, not loads)
    always_comb begin
        loadSum = '0;
        for (int i = 0; i < NUM_STRB; i++) loadSum = loadSum + {4'b0, strobes[i]};
    end

    // Registered strobe count and sticky over-limit flag; loads proceed regardless
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            load_count <= loadSum;
            if (int'(loadSum) > MAX_LOADS) load_err <= 1'b1;
        end
    end

`ifdef R0_BA_GATE_EN
    assign R0_q = BAout ? '0 : gprQ[0];
`else
    assign R0_q = gprQ[0];
`endif
    assign R1_q  = gprQ[1];
    assign R2_q  = gprQ[2];
    assign R3_q  = gprQ[3];
    assign R4_q  = gprQ[4];
    assign R5_q  = gprQ[5];
    assign R6_q  = gprQ[6];
    assign R7_q  = gprQ[7];
    assign R8_q  = gprQ[8];
    assign R9_q  = gprQ[9];
    assign R10_q = gprQ[10];
    assign R11_q = gprQ[11];
    assign R12_q = gprQ[12];
    assign R13_q = gprQ[13];
    assign R14_q = gprQ[14];
    assign R15_q = gprQ[15];
    assign HI_q  = spcQ[0];
    assign LO_q  = spcQ[1];
    assign Y_q   = spcQ[2];
    assign IR_q  = spcQ[3];
    assign MAR_q = spcQ[4];
endmodule
